// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder controller: drives one full-adder cell over WIDTH-bit
// operands, one bit per clock, LSB first, assembling the sum in a shift
// register and reporting completion with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the registered ovf port).
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   operation request, sampled only in IDLE
//   A, B   in   WIDTH-bit operands, captured on accepted start
//   Cin    in   carry-in, captured on accepted start
//   busy   out  high while the bit loop runs
//   done   out  one-cycle pulse, S/Cout (and ovf) valid
//   S      out  WIDTH-bit sum (shift register, partial while busy)
//   Cout   out  final carry-out
//   ovf    out  signed overflow (only with SERIAL_ADD_OVF_EN)
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    // Shared full-adder cell on the current LSB pair and the registered carry
    logic w_sum;
    logic w_carry;
    assign w_sum   = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_carry = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);

    // Sequencer: state, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_c     <= Cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Sum bit enters at the MSB so bit i lands in S[i] after WIDTH shifts
                    S      <= {w_sum, S[WIDTH-1:1]};
                    r_c    <= w_carry;
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        Cout    <= w_carry;
`ifdef SERIAL_ADD_OVF_EN
                        // r_c is the carry into the MSB on this final bit
                        ovf     <= r_c ^ w_carry;
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit addition and sign-rule overflow
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] s, output logic cout, output logic ov);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        s    = full[W-1:0];
        cout = full[W];
        ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    endtask

    // One complete operation from IDLE with latency, busy and pulse checks
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string nm);
        int m;
        int bc;
        bit got;
        m = 0; bc = 0; got = 0;
        @(negedge clk);
        A = a; B = b; Cin = cin; start = 1'b1;
        @(posedge clk);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t == 0) begin
                start = 1'b0;
                A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            end
            if (done) begin
                got = 1;
                break;
            end
            if (busy) bc++;
            m++;
        end
        chk({nm, "_latency"}, 32'(m), 32'(W));
        chk({nm, "_busy_cycles"}, 32'(bc), 32'(W));
        chk({nm, "_busy_at_done"}, 32'(busy), 32'(0));
        chk({nm, "_S"}, 32'(S), 32'(es));
        chk({nm, "_Cout"}, 32'(Cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: ovf unused");
`endif
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'(0));
        chk({nm, "_S_hold"}, 32'(S), 32'(es));
        if (!got) $display("FAIL %s_timeout: no done within 40 cycles", nm);
    endtask

    vec_t vecs[7];

    initial begin
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           m;
        bit           saw_done;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_S", 32'(S), 32'(0));
        chk("rst_Cout", 32'(Cout), 32'(0));
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].cout, vecs[i].ovf,
                   $sformatf("vec%0d", i));

        // start held high through RUN/DONE: second op only accepted back in IDLE
        @(negedge clk);
        A = 8'h55; B = 8'hAA; Cin = 1'b0; start = 1'b1;
        @(posedge clk);
        m = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t == 0) begin A = 8'h01; B = 8'h01; end
            if (done) break;
            m++;
        end
        chk("hold_latency", 32'(m), 32'(W));
        chk("hold_S", 32'(S), 32'h0000_00FF);
        chk("hold_Cout", 32'(Cout), 32'(0));
        @(negedge clk);
        chk("hold_idle_gap_busy", 32'(busy), 32'(0));
        @(negedge clk);
        chk("hold_reaccept_busy", 32'(busy), 32'(1));
        chk("hold_S_stable_after_accept", 32'(S), 32'h0000_00FF);
        start = 1'b0;
        m = 1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done) break;
            m++;
        end
        chk("hold2_latency", 32'(m), 32'(W));
        chk("hold2_S", 32'(S), 32'h0000_0002);
        chk("hold2_Cout", 32'(Cout), 32'(0));
        @(negedge clk);

        // Asynchronous reset after 3 RUN cycles
        @(negedge clk);
        A = 8'h5A; B = 8'h33; Cin = 1'b0; start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_S", 32'(S), 32'(0));
        chk("arst_Cout", 32'(Cout), 32'(0));
`ifdef SERIAL_ADD_OVF_EN
        chk("arst_ovf", 32'(ovf), 32'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        for (int t = 0; t < 2 * W; t++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        chk("arst_no_done", 32'(saw_done), 32'(0));
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, "post_rst");

        // Randomised operations against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, es, ec, eo);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(ra, rb, rc, es, ec, eo, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
